// File: rtl/trivium_ctrl_if.sv
// trivium_ctrl_if: host-side key/IV, input-data and output-data handshakes
interface trivium_ctrl_if #(
  parameter int W     = 8,
  parameter int KEY_W = 80,
  parameter int IV_W  = 80
);
  logic             key_valid;
  logic [KEY_W-1:0] key;
  logic [IV_W-1:0]  iv;
  logic             key_ready;
  logic             din_valid;
  logic [W-1:0]     din;
  logic             din_last;
  logic             din_ready;
  logic             dout_valid;
  logic [W-1:0]     dout;
  logic             dout_last;
  logic             dout_ready;
  modport master (
    output key_valid, key, iv, din_valid, din, din_last, dout_ready,
    input  key_ready, din_ready, dout_valid, dout, dout_last
  );
  modport slave (
    input  key_valid, key, iv, din_valid, din, din_last, dout_ready,
    output key_ready, din_ready, dout_valid, dout, dout_last
  );
endinterface

// File: rtl/trivium_ctrl.sv
// trivium_ctrl: sequences a bit-serial Trivium core through load, warm-up and per-word keystream XOR
module trivium_ctrl #(
  parameter int W      = 8,
  parameter int KEY_W  = 80,
  parameter int IV_W   = 80,
  parameter int WARMUP = 1152
) (
  input  logic             clk,
  input  logic             rst,
  trivium_ctrl_if.slave    bus,
  output logic             core_load_o,
  output logic [KEY_W-1:0] core_key_o,
  output logic [IV_W-1:0]  core_iv_o,
  output logic             core_en_o,
  input  logic             core_z_i,
  output logic             busy_o,
  output logic             err_o
);
  localparam int CW = $clog2(WARMUP) + 1;
  localparam int BW = $clog2(W);
  typedef enum logic [2:0] {IDLE, LOAD, WARM, READY, GEN, OUT, ERROR} state_t;
  state_t           state_q;
  logic             key_ready_q, din_ready_q, core_load_q, core_en_q, busy_q, err_q;
  logic             dout_valid_q, dout_last_q, last_q;
  logic [W-1:0]     dout_q, din_q;
  logic [W-2:0]     ks_q;
  logic [KEY_W-1:0] key_q;
  logic [IV_W-1:0]  iv_q;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    bit_q;
  // Control FSM; every output is a register set on the transition into the state that owns it.
  // Keystream bits shift in from the top so the first GEN bit lands in ks_q[0] (LSB).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      key_ready_q  <= 1'b1;
      din_ready_q  <= 1'b0;
      core_load_q  <= 1'b0;
      core_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      last_q       <= 1'b0;
      dout_q       <= '0;
      din_q        <= '0;
      ks_q         <= '0;
      key_q        <= '0;
      iv_q         <= '0;
      cnt_q        <= '0;
      bit_q        <= '0;
    end else begin
      core_load_q <= 1'b0;
      case (state_q)
        IDLE, ERROR: begin
          if (bus.key_valid) begin
            key_q       <= bus.key;
            iv_q        <= bus.iv;
            err_q       <= 1'b0;
            core_load_q <= 1'b1;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
          end else if (state_q == IDLE && bus.din_valid) begin
            err_q   <= 1'b1;
            state_q <= ERROR;
          end
        end
        LOAD: begin
          cnt_q     <= '0;
          core_en_q <= 1'b1;
          state_q   <= WARM;
        end
        WARM: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WARMUP - 1)) begin
            core_en_q   <= 1'b0;
            din_ready_q <= 1'b1;
            state_q     <= READY;
          end
        end
        READY: begin
          if (bus.din_valid) begin
            din_q       <= bus.din;
            last_q      <= bus.din_last;
            bit_q       <= '0;
            din_ready_q <= 1'b0;
            core_en_q   <= 1'b1;
            state_q     <= GEN;
          end
        end
        GEN: begin
          ks_q  <= {core_z_i, ks_q[W-2:1]};
          bit_q <= bit_q + 1'b1;
          if (bit_q == BW'(W - 1)) begin
            core_en_q    <= 1'b0;
            dout_q       <= din_q ^ {core_z_i, ks_q};
            dout_last_q  <= last_q;
            dout_valid_q <= 1'b1;
            state_q      <= OUT;
          end
        end
        OUT: begin
          if (bus.dout_ready) begin
            dout_valid_q <= 1'b0;
            key_ready_q  <= last_q;
            din_ready_q  <= ~last_q;
            busy_q       <= ~last_q;
            state_q      <= last_q ? IDLE : READY;
          end
        end
        default: begin
          key_ready_q <= 1'b1;
          din_ready_q <= 1'b0;
          core_en_q   <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end
  assign bus.key_ready  = key_ready_q;
  assign bus.din_ready  = din_ready_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout       = dout_q;
  assign bus.dout_last  = dout_last_q;
  assign core_load_o    = core_load_q;
  assign core_key_o     = key_q;
  assign core_iv_o      = iv_q;
  assign core_en_o      = core_en_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;
endmodule

// File: tb/tb_trivium_ctrl.sv
// tb_trivium_ctrl: directed checks of the Trivium sequencer with a stubbed keystream bit
module tb_trivium_ctrl;
  localparam int W = 8, KEY_W = 80, IV_W = 80, WARMUP = 1152;
  logic             clk = 1'b0;
  logic             rst;
  logic             core_load, core_en, core_z, busy, err;
  logic [KEY_W-1:0] core_key;
  logic [IV_W-1:0]  core_iv;
  int               n_checks = 0;
  int               n_fail = 0;
  trivium_ctrl_if #(.W(W), .KEY_W(KEY_W), .IV_W(IV_W)) bus ();
  trivium_ctrl #(.W(W), .KEY_W(KEY_W), .IV_W(IV_W), .WARMUP(WARMUP)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .core_load_o(core_load), .core_key_o(core_key), .core_iv_o(core_iv),
    .core_en_o(core_en), .core_z_i(core_z), .busy_o(busy), .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic key_hs(input logic [KEY_W-1:0] k, input logic [IV_W-1:0] v);
    bus.key = k;
    bus.iv = v;
    bus.key_valid = 1'b1;
    step();
    bus.key_valid = 1'b0;
  endtask
  task automatic count_warm(output int n);
    n = 0;
    while (core_en && n < 2000) begin
      n++;
      step();
    end
  endtask
  task automatic din_hs(input logic [W-1:0] d, input logic l);
    bus.din = d;
    bus.din_last = l;
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
  endtask
  logic [KEY_W-1:0] key_a;
  logic [W-1:0]     held;
  int               n, cyc, bad_stable, bad_en, bad_rdy;
  initial begin
    key_a = 80'h0123456789ABCDEF0123;
    rst = 1'b1;
    core_z = 1'b0;
    bus.key_valid = 1'b0;
    bus.key = '0;
    bus.iv = '0;
    bus.din_valid = 1'b0;
    bus.din = '0;
    bus.din_last = 1'b0;
    bus.dout_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_key_ready", bus.key_ready, 1);
    check("rst_din_ready", bus.din_ready, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_core_en", core_en, 0);
    check("rst_core_load", core_load, 0);
    check("rst_busy", busy, 0);
    check("rst_core_key", core_key, 0);
    // data offered with no key -> sticky error, word not taken
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
    check("err_set", err, 1);
    check("err_din_ready", bus.din_ready, 0);
    check("err_key_ready", bus.key_ready, 1);
    step();
    check("err_sticky", err, 1);
    // key handshake clears the error and pulses load
    key_hs(key_a, '0);
    check("load_err_clr", err, 0);
    check("load_pulse", core_load, 1);
    check("load_core_en", core_en, 0);
    check("load_busy", busy, 1);
    check("load_key_ready", bus.key_ready, 0);
    check("core_key", core_key, key_a);
    check("core_iv", core_iv, 0);
    step();
    check("load_one_cycle", core_load, 0);
    count_warm(n);
    check("warm_len", n, WARMUP);
    check("ready_after_warm", bus.din_ready, 1);
    check("ready_busy", busy, 1);
    // constant-one keystream inverts the word
    core_z = 1'b1;
    din_hs(8'h5A, 1'b1);
    check("gen_din_ready", bus.din_ready, 0);
    cyc = 1;
    while (!bus.dout_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check("latency", cyc, W + 1);
    check("dout_ones", bus.dout, 8'hA5);
    check("dout_last1", bus.dout_last, 1);
    // downstream stall: output frozen, core idle, new data refused
    held = bus.dout;
    bad_stable = 0;
    bad_en = 0;
    bad_rdy = 0;
    bus.din = 8'h33;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.dout !== held || bus.dout_valid !== 1'b1) bad_stable++;
      if (core_en !== 1'b0) bad_en++;
      if (bus.din_ready !== 1'b0) bad_rdy++;
    end
    bus.din_valid = 1'b0;
    check("stall_dout_stable", bad_stable, 0);
    check("stall_core_en", bad_en, 0);
    check("stall_din_ready", bad_rdy, 0);
    bus.dout_ready = 1'b1;
    step();
    bus.dout_ready = 1'b0;
    check("accept_dout_valid", bus.dout_valid, 0);
    check("last_to_idle", bus.key_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_err", err, 0);
    // rekey, then alternating keystream 1,0,1,0... LSB first
    key_hs(80'hFFFF0000FFFF0000FFFF, 80'h1);
    step();
    count_warm(n);
    check("warm_len2", n, WARMUP);
    bus.din = 8'h00;
    bus.din_last = 1'b0;
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      core_z = (i % 2 == 0);
      step();
    end
    check("alt_valid", bus.dout_valid, 1);
    check("dout_alt", bus.dout, 8'h55);
    check("dout_last0", bus.dout_last, 0);
    bus.dout_ready = 1'b1;
    step();
    bus.dout_ready = 1'b0;
    check("not_last_to_ready", bus.din_ready, 1);
    check("not_last_key_ready", bus.key_ready, 0);
    // reset in the middle of a word
    core_z = 1'b1;
    din_hs(8'hC3, 1'b0);
    step();
    step();
    check("mid_gen_core_en", core_en, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_core_en", core_en, 0);
    check("mrst_dout_valid", bus.dout_valid, 0);
    check("mrst_key_ready", bus.key_ready, 1);
    check("mrst_busy", busy, 0);
    check("mrst_core_key", core_key, 0);
    step();
    check("mrst_stays_idle", core_en, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
